// File: rtl/vending_machine_param.sv
// Parameterised vending machine: slot select, coin credit, vend handshake and
// greedy change return, with per-slot price/stock tables loaded at reset.
module vending_machine_param #(
  parameter  int NUM_PRODUCTS = 8,
  parameter  int BAL_W        = 8,
  parameter  int STOCK_W      = 4,
  parameter  int INIT_STOCK   = 5,
  parameter  int DEF_PRICE    = 25,
  localparam int PID_W        = $clog2(NUM_PRODUCTS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sel_valid,
  input  logic [PID_W-1:0]   sel_id,
  input  logic               coin_valid,
  input  logic [6:0]         coin_value,
  input  logic               cancel,
  input  logic               cfg_we,
  input  logic [PID_W-1:0]   cfg_id,
  input  logic [BAL_W-1:0]   cfg_price,
  input  logic [STOCK_W-1:0] cfg_stock,
  input  logic               vend_ready,
  input  logic               chg_ready,
  output logic [BAL_W-1:0]   balance,
  output logic [BAL_W-1:0]   price,
  output logic               vend_valid,
  output logic [PID_W-1:0]   vend_id,
  output logic               chg_valid,
  output logic [6:0]         chg_value,
  output logic               coin_reject,
  output logic               sold_out,
  output logic               txn_done,
  output logic [2:0]         state_out
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECTED = 3'd1,
    CREDIT   = 3'd2,
    VEND     = 3'd3,
    CHANGE   = 3'd4
  } state_t;

  // Arithmetic width wide enough for both the balance and a 7-bit coin plus carry.
  localparam int SW = ((BAL_W > 7) ? BAL_W : 7) + 1;
  localparam logic [PID_W:0] NP_LIM = (PID_W+1)'(NUM_PRODUCTS);

  state_t             state_reg, state_next;
  logic [BAL_W-1:0]   balance_reg, balance_next;
  logic [PID_W-1:0]   slot_reg, slot_next;
  logic               sold_out_reg, sold_out_next;
  logic               coin_reject_reg, coin_reject_next;
  logic               txn_done_reg, txn_done_next;

  logic [STOCK_W-1:0] stock_reg [NUM_PRODUCTS];
  logic [BAL_W-1:0]   price_reg [NUM_PRODUCTS];

  logic               cfg_hit, vend_hit;
  logic               sel_has_stock, cfg_in_range;
  logic               coin_legal, coin_ok;
  logic [SW-1:0]      coin_sum;
  logic [BAL_W-1:0]   cur_price;
  logic [6:0]         chg_coin;

  assign cur_price     = price_reg[slot_reg];
  assign sel_has_stock = ({1'b0, sel_id} < NP_LIM) && (stock_reg[sel_id] != '0);
  assign cfg_in_range  = ({1'b0, cfg_id} < NP_LIM);
  assign coin_legal    = (coin_value == 7'd5)  || (coin_value == 7'd10) ||
                         (coin_value == 7'd20) || (coin_value == 7'd50);
  assign coin_sum      = SW'(balance_reg) + SW'(coin_value);
  assign coin_ok       = coin_valid && coin_legal && ((coin_sum >> BAL_W) == '0);

  // Greedy change; a sub-5 remainder (odd price) is paid out as-is so CHANGE always drains.
  always_comb begin
    if (SW'(balance_reg) >= SW'(50))      chg_coin = 7'd50;
    else if (SW'(balance_reg) >= SW'(20)) chg_coin = 7'd20;
    else if (SW'(balance_reg) >= SW'(10)) chg_coin = 7'd10;
    else if (SW'(balance_reg) >= SW'(5))  chg_coin = 7'd5;
    else                                  chg_coin = 7'(balance_reg);
  end

  always_comb begin
    state_next       = state_reg;
    balance_next     = balance_reg;
    slot_next        = slot_reg;
    sold_out_next    = 1'b0;
    coin_reject_next = coin_valid;
    txn_done_next    = 1'b0;
    cfg_hit          = 1'b0;
    vend_hit         = 1'b0;
    case (state_reg)
      IDLE: begin
        balance_next = '0;
        if (sel_valid) begin
          if (sel_has_stock) begin
            slot_next  = sel_id;
            state_next = SELECTED;
          end else begin
            sold_out_next = 1'b1;
          end
        end else if (cfg_we && cfg_in_range) begin
          cfg_hit = 1'b1;
        end
      end
      SELECTED: begin
        if (cancel) begin
          state_next    = IDLE;
          txn_done_next = 1'b1;
        end else if (coin_ok) begin
          balance_next     = coin_sum[BAL_W-1:0];
          coin_reject_next = 1'b0;
          state_next       = CREDIT;
        end else if (cur_price == '0) begin
          state_next = VEND;
        end
      end
      CREDIT: begin
        if (cancel) begin
          state_next = CHANGE;
        end else begin
          if (coin_ok) begin
            balance_next     = coin_sum[BAL_W-1:0];
            coin_reject_next = 1'b0;
          end
          if (balance_reg >= cur_price) state_next = VEND;
        end
      end
      VEND: begin
        if (vend_ready) begin
          vend_hit     = 1'b1;
          balance_next = balance_reg - cur_price;
          if (balance_reg != cur_price) begin
            state_next = CHANGE;
          end else begin
            state_next    = IDLE;
            txn_done_next = 1'b1;
          end
        end
      end
      CHANGE: begin
        if (balance_reg == '0) begin
          state_next    = IDLE;
          txn_done_next = 1'b1;
        end else if (chg_ready) begin
          balance_next = balance_reg - BAL_W'(chg_coin);
          if (SW'(balance_reg) == SW'(chg_coin)) begin
            state_next    = IDLE;
            txn_done_next = 1'b1;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        balance_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      balance_reg     <= '0;
      slot_reg        <= '0;
      sold_out_reg    <= 1'b0;
      coin_reject_reg <= 1'b0;
      txn_done_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      balance_reg     <= balance_next;
      slot_reg        <= slot_next;
      sold_out_reg    <= sold_out_next;
      coin_reject_reg <= coin_reject_next;
      txn_done_reg    <= txn_done_next;
    end
  end

  // Per-slot tables; a vend never takes stock below zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_slot
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stock_reg[gi] <= STOCK_W'(INIT_STOCK);
          price_reg[gi] <= BAL_W'(DEF_PRICE);
        end else if (cfg_hit && (cfg_id == PID_W'(gi))) begin
          stock_reg[gi] <= cfg_stock;
          price_reg[gi] <= cfg_price;
        end else if (vend_hit && (slot_reg == PID_W'(gi)) && (stock_reg[gi] != '0)) begin
          stock_reg[gi] <= stock_reg[gi] - STOCK_W'(1);
        end
      end
    end
  endgenerate

  assign balance     = balance_reg;
  assign price       = cur_price;
  assign vend_valid  = (state_reg == VEND);
  assign vend_id     = slot_reg;
  assign chg_valid   = (state_reg == CHANGE) && (balance_reg != '0);
  assign chg_value   = chg_coin;
  assign coin_reject = coin_reject_reg;
  assign sold_out    = sold_out_reg;
  assign txn_done    = txn_done_reg;
  assign state_out   = state_reg;

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: directed purchases push expected
// handshakes/pulses into queues; a negedge monitor pops and compares them.
module tb_vending_machine_param;
  localparam int PW = 3;
  localparam int BW = 8;
  localparam int SWD = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           sel_valid = 1'b0;
  logic [PW-1:0]  sel_id = '0;
  logic           coin_valid = 1'b0;
  logic [6:0]     coin_value = '0;
  logic           cancel = 1'b0;
  logic           cfg_we = 1'b0;
  logic [PW-1:0]  cfg_id = '0;
  logic [BW-1:0]  cfg_price = '0;
  logic [SWD-1:0] cfg_stock = '0;
  logic           vend_ready = 1'b0;
  logic           chg_ready = 1'b0;
  logic [BW-1:0]  balance, price;
  logic           vend_valid, chg_valid, coin_reject, sold_out, txn_done;
  logic [PW-1:0]  vend_id;
  logic [6:0]     chg_value;
  logic [2:0]     state_out;

  int n_checks = 0;
  int n_fail = 0;
  int exp_vend[$];
  int exp_chg[$];
  int exp_rej[$];
  int exp_sold[$];
  int exp_done[$];

  vending_machine_param dut (
    .clk(clk), .reset_n(reset_n), .sel_valid(sel_valid), .sel_id(sel_id),
    .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
    .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_price(cfg_price), .cfg_stock(cfg_stock),
    .vend_ready(vend_ready), .chg_ready(chg_ready), .balance(balance), .price(price),
    .vend_valid(vend_valid), .vend_id(vend_id), .chg_valid(chg_valid),
    .chg_value(chg_value), .coin_reject(coin_reject), .sold_out(sold_out),
    .txn_done(txn_done), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, ref int q[$], input int act);
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got unexpected event (value %0d), required none", name, act);
    end else begin
      int e;
      e = q.pop_front();
      if (act != e) begin
        n_fail++;
        $display("FAIL %s: got %0d, required %0d", name, act, e);
      end else begin
        $display("txn %s value %0d at %0t", name, act, $time);
      end
    end
  endtask

  // Monitor: one pop per observed handshake or pulse.
  always @(negedge clk) begin
    if (reset_n) begin
      if (vend_valid && vend_ready) pop_chk("vend_id", exp_vend, int'(vend_id));
      if (chg_valid && chg_ready)   pop_chk("chg_value", exp_chg, int'(chg_value));
      if (coin_reject)              pop_chk("coin_reject_balance", exp_rej, int'(balance));
      if (sold_out)                 pop_chk("sold_out_state", exp_sold, int'(state_out));
      if (txn_done)                 pop_chk("txn_done_balance", exp_done, int'(balance));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sel(input int id);
    sel_valid = 1'b1; sel_id = PW'(id);
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic do_coin(input int v);
    coin_valid = 1'b1; coin_value = 7'(v);
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic do_cfg(input int id, input int p, input int s);
    cfg_we = 1'b1; cfg_id = PW'(id); cfg_price = BW'(p); cfg_stock = SWD'(s);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n;
    n = 0;
    while (int'(state_out) != s && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(state_out), s);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(state_out), 0);
    chk("reset_balance", int'(balance), 0);
    chk("reset_vend_valid", int'(vend_valid), 0);
    chk("reset_price", int'(price), 25);
    reset_n = 1'b1;
    tick();

    // Slot 2 at 25: 20 + 10 -> vend 2, one 5 change coin.
    vend_ready = 1'b1; chg_ready = 1'b1;
    exp_vend.push_back(2); exp_chg.push_back(5); exp_done.push_back(0);
    do_sel(2);
    chk("a_selected", int'(state_out), 1);
    do_coin(20);
    chk("a_credit_bal", int'(balance), 20);
    do_coin(10);
    chk("a_credit_bal2", int'(balance), 30);
    wait_state(3, 10, "a_vend_state");
    wait_state(0, 20, "a_idle");
    chk("a_idle_balance", int'(balance), 0);

    // Slot 7 reconfigured to price 50, stock 1: exact payment, then sold out.
    do_cfg(7, 50, 1);
    exp_vend.push_back(7); exp_done.push_back(0);
    do_sel(7);
    chk("b_price", int'(price), 50);
    do_coin(50);
    wait_state(0, 20, "b_idle");
    exp_sold.push_back(0);
    do_sel(7);
    tick();
    chk("b_sold_stays_idle", int'(state_out), 0);

    // Slot 0, 100 credit; change held while hopper stalls, then 50, 20, 5.
    chg_ready = 1'b0;
    exp_vend.push_back(0);
    do_sel(0);
    do_coin(50);
    do_coin(50);
    wait_state(4, 10, "c_change_state");
    chk("c_change_bal", int'(balance), 75);
    for (int i = 0; i < 3; i++) begin
      chk("c_chg_valid_held", int'(chg_valid), 1);
      chk("c_chg_value_held", int'(chg_value), 50);
      tick();
    end
    exp_chg.push_back(50); exp_chg.push_back(20); exp_chg.push_back(5);
    exp_done.push_back(0);
    chg_ready = 1'b1;
    wait_state(0, 20, "c_idle");
    chk("c_idle_balance", int'(balance), 0);

    // Cancel and coin together in CREDIT: coin rejected, 10 refunded.
    do_sel(1);
    do_coin(10);
    exp_rej.push_back(10); exp_chg.push_back(10); exp_done.push_back(0);
    cancel = 1'b1; coin_valid = 1'b1; coin_value = 7'd20;
    tick();
    cancel = 1'b0; coin_valid = 1'b0;
    chk("d_change_state", int'(state_out), 4);
    chk("d_change_bal", int'(balance), 10);
    wait_state(0, 20, "d_idle");

    // Coin in IDLE, illegal 15 in SELECTED, then overflow at 250 + 10.
    exp_rej.push_back(0);
    do_coin(20);
    chk("e_idle_bal", int'(balance), 0);
    do_sel(3);
    exp_rej.push_back(0);
    do_coin(15);
    chk("e_illegal_state", int'(state_out), 1);
    chk("e_illegal_bal", int'(balance), 0);
    exp_done.push_back(0);
    do_cancel();
    chk("e_cancel_idle", int'(state_out), 0);
    do_cfg(4, 255, 3);
    do_sel(4);
    chk("e_price255", int'(price), 255);
    for (int i = 0; i < 5; i++) do_coin(50);
    chk("e_bal250", int'(balance), 250);
    exp_rej.push_back(250);
    do_coin(10);
    chk("e_overflow_bal", int'(balance), 250);
    chk("e_overflow_state", int'(state_out), 2);
    exp_vend.push_back(4); exp_done.push_back(0);
    do_coin(5);
    chk("e_bal255", int'(balance), 255);
    wait_state(0, 20, "e_idle");

    // Reset asserted while vend_valid is high.
    vend_ready = 1'b0;
    do_cfg(5, 30, 1);
    do_sel(5);
    chk("f_price30", int'(price), 30);
    do_coin(50);
    wait_state(3, 10, "f_vend_state");
    chk("f_vend_valid", int'(vend_valid), 1);
    chk("f_vend_id", int'(vend_id), 5);
    #2 reset_n = 1'b0;
    #1;
    chk("f_rst_state", int'(state_out), 0);
    chk("f_rst_balance", int'(balance), 0);
    chk("f_rst_vend_valid", int'(vend_valid), 0);
    chk("f_rst_price", int'(price), 25);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    do_sel(5);
    chk("f_price_restored", int'(price), 25);
    exp_done.push_back(0);
    do_cancel();
    do_sel(7);
    chk("f_stock_restored", int'(state_out), 1);
    exp_done.push_back(0);
    do_cancel();
    repeat (4) tick();

    chk("q_vend_empty", exp_vend.size(), 0);
    chk("q_chg_empty", exp_chg.size(), 0);
    chk("q_rej_empty", exp_rej.size(), 0);
    chk("q_sold_empty", exp_sold.size(), 0);
    chk("q_done_empty", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
